// File: rtl/mnist_infer_ctrl.sv
// mnist_infer_ctrl: streams one image frame from the image RAM into the
// network core, then waits (bounded) for the class result.
//   clk, rst            - single clock, synchronous active-high reset
//   start, abort        - frame request / cancel
//   pix_addr, pix_data  - image RAM read port (data returned for the address
//                         held in the previous cycle)
//   core_valid_in, core_pixel       - pixel stream to the network core
//   core_result, core_result_valid  - class result from the network core
//   busy, done, class_out, timeout_err, frame_cnt - status
module mnist_infer_ctrl #(
  parameter int unsigned NUM_PIXELS     = 784,
  parameter int unsigned PIXEL_GAP      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [9:0]  pix_addr,
  input  logic [7:0]  pix_data,
  output logic        core_valid_in,
  output logic [7:0]  core_pixel,
  input  logic [31:0] core_result,
  input  logic        core_result_valid,
  output logic        busy,
  output logic        done,
  output logic [31:0] class_out,
  output logic        timeout_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_PIXELS) + 1;
  localparam int unsigned GAP_W = $clog2(PIXEL_GAP) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               issue_q, issue_d;
  logic [9:0]         pix_addr_q, pix_addr_d;
  logic               core_valid_q, core_valid_d;
  logic [7:0]         core_pixel_q, core_pixel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        class_q, class_d;
  logic               terr_q, terr_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    tmo_d        = tmo_q;
    issue_d      = 1'b0;
    pix_addr_d   = pix_addr_q;
    core_valid_d = issue_q;
    core_pixel_d = core_pixel_q;
    class_d      = class_q;
    terr_d       = terr_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_STREAM;
          idx_d      = '0;
          gap_d      = '0;
          pix_addr_d = '0;
          terr_d     = 1'b0;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d      = S_IDLE;
          core_valid_d = 1'b0;
        end else if (idx_q < IDX_W'(NUM_PIXELS)) begin
          if (gap_q == '0) begin
            issue_d    = 1'b1;
            pix_addr_d = 10'(idx_q);
            idx_d      = idx_q + IDX_W'(1);
            gap_d      = GAP_W'(PIXEL_GAP);
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end else if (issue_q) begin
          // Last pixel is being presented this edge
          state_d = S_WAIT_RES;
          tmo_d   = '0;
        end
      end
      S_WAIT_RES: begin
        if (abort) begin
          state_d      = S_IDLE;
          core_valid_d = 1'b0;
        end else if (core_result_valid) begin
          // Result wins over a coincident timeout terminal count
          state_d     = S_DONE;
          class_d     = core_result;
          frame_cnt_d = frame_cnt_q + 16'd1;
          done_d      = 1'b1;
        end else if (tmo_q + TMO_W'(1) == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // RAM data for the address issued last cycle rides with the strobe
    if (core_valid_d) begin
      core_pixel_d = pix_data;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      tmo_q        <= '0;
      issue_q      <= 1'b0;
      pix_addr_q   <= '0;
      core_valid_q <= 1'b0;
      core_pixel_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      class_q      <= '0;
      terr_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      tmo_q        <= tmo_d;
      issue_q      <= issue_d;
      pix_addr_q   <= pix_addr_d;
      core_valid_q <= core_valid_d;
      core_pixel_q <= core_pixel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      class_q      <= class_d;
      terr_q       <= terr_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pix_addr      = pix_addr_q;
  assign core_valid_in = core_valid_q;
  assign core_pixel    = core_pixel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign class_out     = class_q;
  assign timeout_err   = terr_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// tb_mnist_infer_ctrl: three controller instances (gap 0 / gap 2 / short
// timeout) driven by directed sequences; a frame-timing model predicts every
// output each cycle, and literal expectations pin key timings.
module tb_mnist_infer_ctrl;

  localparam int NI   = 3;
  localparam int NPIX = 784;

  function automatic int gap_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int tmo_of(input int i);
    return (i == 2) ? 10 : ((i == 1) ? 65535 : 200);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [NI];
  logic        abort [NI];
  logic        crv   [NI];
  logic [31:0] cres  [NI];
  logic [9:0]  pix_addr [NI];
  logic [7:0]  pix_data [NI];
  logic        cvi   [NI];
  logic [7:0]  cpix  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic [31:0] cls   [NI];
  logic        terr  [NI];
  logic [15:0] fcnt  [NI];

  logic [7:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = 8'(i % 256);

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mnist_infer_ctrl #(
      .NUM_PIXELS    (NPIX),
      .PIXEL_GAP     (gap_of(gi)),
      .TIMEOUT_CYCLES(tmo_of(gi))
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start[gi]),
      .abort            (abort[gi]),
      .pix_addr         (pix_addr[gi]),
      .pix_data         (pix_data[gi]),
      .core_valid_in    (cvi[gi]),
      .core_pixel       (cpix[gi]),
      .core_result      (cres[gi]),
      .core_result_valid(crv[gi]),
      .busy             (busy[gi]),
      .done             (done[gi]),
      .class_out        (cls[gi]),
      .timeout_err      (terr[gi]),
      .frame_cnt        (fcnt[gi])
    );
    assign pix_data[gi] = ram[pix_addr[gi]];
  end

  // ---------------- frame-timing model ----------------
  // Each frame is described by its start edge s; issue j happens at edge
  // s+1+j*(G+1), its strobe one edge later, and the result window opens
  // once the last strobe edge has passed.
  int          m_e = -1;
  bit          m_ok = 1'b0;
  bit          m_act [NI];
  bit          m_dn  [NI];
  int          m_s   [NI];
  logic [9:0]  e_addr [NI];
  logic        e_valid[NI];
  logic [7:0]  e_pix  [NI];
  logic        e_busy [NI];
  logic        e_done [NI];
  logic [31:0] e_cls  [NI];
  logic        e_terr [NI];
  logic [15:0] e_fc   [NI];

  always @(posedge clk) begin : model
    int e, s, we, k, g, t;
    bit act, dn, vld;
    logic [9:0]  a;
    logic [7:0]  p;
    logic [31:0] c;
    logic        te;
    logic [15:0] f;
    e = m_e + 1;
    for (int i = 0; i < NI; i++) begin
      act = m_act[i]; dn = m_dn[i]; s = m_s[i];
      a = e_addr[i]; p = e_pix[i]; c = e_cls[i]; te = e_terr[i]; f = e_fc[i];
      g = gap_of(i) + 1; t = tmo_of(i); vld = 1'b0;
      if (rst) begin
        act = 1'b0; dn = 1'b0; a = '0; p = '0; c = '0; te = 1'b0; f = '0;
      end else if (dn) begin
        dn = 1'b0;
      end else if (!act) begin
        if (start[i]) begin
          act = 1'b1; s = e; te = 1'b0; a = '0;
        end
      end else begin
        we = s + 2 + (NPIX - 1) * g;
        if (abort[i]) begin
          act = 1'b0;
        end else if (e - 1 >= we && crv[i]) begin
          c = cres[i]; f = f + 16'd1; act = 1'b0; dn = 1'b1;
        end else if (e - we == t) begin
          te = 1'b1; act = 1'b0; dn = 1'b1;
        end else begin
          k = e - s - 1;
          if (k >= 0 && k % g == 0 && k / g < NPIX) a = 10'(k / g);
          k = e - s - 2;
          if (k >= 0 && k % g == 0 && k / g < NPIX) begin
            vld = 1'b1; p = ram[k / g];
          end
        end
      end
      m_act[i]   <= act;
      m_dn[i]    <= dn;
      m_s[i]     <= s;
      e_addr[i]  <= a;
      e_pix[i]   <= p;
      e_cls[i]   <= c;
      e_terr[i]  <= te;
      e_fc[i]    <= f;
      e_valid[i] <= vld;
      e_busy[i]  <= act | dn;
      e_done[i]  <= dn;
    end
    m_e <= e;
    if (rst) m_ok <= 1'b1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int f_nv   [NI];
  int f_first[NI];
  int f_last [NI];
  int n_done [NI];
  int d_edge [NI];
  bit busy_p [NI];

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", nm, i, m_e, a, x);
    end
  endtask

  // One cycle: step to the falling edge, compare every instance to the model
  task automatic tick();
    @(negedge clk);
    if (m_ok) begin
      for (int i = 0; i < NI; i++) begin
        chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
        chk("done", i, 32'(done[i]), 32'(e_done[i]));
        chk("pix_addr", i, 32'(pix_addr[i]), 32'(e_addr[i]));
        chk("core_valid_in", i, 32'(cvi[i]), 32'(e_valid[i]));
        chk("core_pixel", i, 32'(cpix[i]), 32'(e_pix[i]));
        chk("class_out", i, cls[i], e_cls[i]);
        chk("timeout_err", i, 32'(terr[i]), 32'(e_terr[i]));
        chk("frame_cnt", i, 32'(fcnt[i]), 32'(e_fc[i]));
        if (busy[i] === 1'b1 && !busy_p[i]) f_nv[i] = 0;
        busy_p[i] = (busy[i] === 1'b1);
        if (cvi[i] === 1'b1) begin
          if (f_nv[i] == 0) f_first[i] = m_e;
          f_last[i] = m_e;
          f_nv[i]++;
        end
        if (done[i] === 1'b1) begin
          n_done[i]++;
          d_edge[i] = m_e;
        end
      end
    end
  endtask

  task automatic wait_edge(input int target);
    while (m_e < target) tick();
  endtask

  task automatic go(input int i, output int base);
    start[i] = 1'b1;
    base = m_e + 1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic result(input int i, input logic [31:0] v);
    crv[i] = 1'b1;
    cres[i] = v;
    tick();
    crv[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b, nd;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; crv[i] = 1'b0; cres[i] = '0;
    end
    tick(); tick();
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_pix_addr", 0, 32'(pix_addr[0]), 32'd0);
    chk("rst_frame_cnt", 0, 32'(fcnt[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame, gap 0, result 7 in cycle 900
    go(0, b);
    wait_edge(b + 900);
    result(0, 32'd7);
    wait_edge(b + 905);
    chk("t1_first_strobe", 0, 32'(f_first[0] - b), 32'd2);
    chk("t1_last_strobe", 0, 32'(f_last[0] - b), 32'd785);
    chk("t1_strobes", 0, 32'(f_nv[0]), 32'd784);
    chk("t1_done_edge", 0, 32'(d_edge[0] - b), 32'd901);
    chk("t1_done_count", 0, 32'(n_done[0]), 32'd1);
    chk("t1_class", 0, cls[0], 32'd7);
    chk("t1_frame_cnt", 0, 32'(fcnt[0]), 32'd1);

    // Gap 2: strobes every 3 cycles
    go(1, b);
    wait_edge(b + 2360);
    result(1, 32'h55);
    wait_edge(b + 2365);
    chk("t2_strobes", 1, 32'(f_nv[1]), 32'd784);
    chk("t2_first_strobe", 1, 32'(f_first[1] - b), 32'd2);
    chk("t2_span", 1, 32'(f_last[1] - f_first[1]), 32'd2349);
    chk("t2_done_edge", 1, 32'(d_edge[1] - b), 32'd2361);
    chk("t2_class", 1, cls[1], 32'h55);

    // Short timeout: good frame, timed-out frame, coincident result/timeout
    go(2, b);
    wait_edge(b + 788);
    result(2, 32'h1234);
    wait_edge(b + 792);
    go(2, b);
    wait_edge(b + 800);
    chk("t3_timeout_err", 2, 32'(terr[2]), 32'd1);
    chk("t3_class_kept", 2, cls[2], 32'h1234);
    chk("t3_frame_cnt", 2, 32'(fcnt[2]), 32'd1);
    chk("t3_done_edge", 2, 32'(d_edge[2] - b), 32'd795);
    chk("t3_done_count", 2, 32'(n_done[2]), 32'd2);
    go(2, b);
    wait_edge(b + 794);
    result(2, 32'hBEEF);
    wait_edge(b + 800);
    chk("t3_tie_terr", 2, 32'(terr[2]), 32'd0);
    chk("t3_tie_class", 2, cls[2], 32'hBEEF);
    chk("t3_tie_done_edge", 2, 32'(d_edge[2] - b), 32'd795);

    // Abort at pixel 300 with a coincident result, then a full frame
    nd = n_done[0];
    go(0, b);
    wait_edge(b + 301);
    abort[0] = 1'b1; crv[0] = 1'b1; cres[0] = 32'hDEAD;
    tick();
    abort[0] = 1'b0; crv[0] = 1'b0;
    wait_edge(b + 310);
    chk("t4_busy", 0, 32'(busy[0]), 32'd0);
    chk("t4_strobes", 0, 32'(f_nv[0]), 32'd300);
    chk("t4_no_done", 0, 32'(n_done[0]), 32'(nd));
    chk("t4_class", 0, cls[0], 32'd7);
    go(0, b);
    wait_edge(b + 850);
    result(0, 32'd9);
    wait_edge(b + 855);
    chk("t4_full_strobes", 0, 32'(f_nv[0]), 32'd784);
    chk("t4_frame_cnt", 0, 32'(fcnt[0]), 32'd2);

    // Start held high, spurious result during streaming
    nd = n_done[0];
    start[0] = 1'b1;
    b = m_e + 1;
    tick();
    wait_edge(b + 100);
    result(0, 32'h77);
    wait_edge(b + 820);
    result(0, 32'h42);
    wait_edge(b + 830);
    start[0] = 1'b0;
    chk("t5_class", 0, cls[0], 32'h42);
    chk("t5_frame_cnt", 0, 32'(fcnt[0]), 32'd3);
    chk("t5_done_count", 0, 32'(n_done[0] - nd), 32'd1);
    chk("t5_restarted", 0, 32'(busy[0]), 32'd1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    tick();

    // Reset while waiting for the result, late result ignored
    nd = n_done[0];
    go(0, b);
    wait_edge(b + 790);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    result(0, 32'h99);
    tick(); tick(); tick();
    chk("t6_busy", 0, 32'(busy[0]), 32'd0);
    chk("t6_class", 0, cls[0], 32'd0);
    chk("t6_frame_cnt", 0, 32'(fcnt[0]), 32'd0);
    chk("t6_no_done", 0, 32'(n_done[0]), 32'(nd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
